ks_adder_pipe: RTL and testbench



---
 rtl/ks_adder_pipe.sv | 174 +++++++++++++++++
 tb/tb_ks_adder_pipe.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshakes.
// Prefix levels are grouped PIPE_EVERY at a time between register stages.
module ks_adder_pipe #(
    parameter int WIDTH      = 32,
    parameter int PIPE_EVERY = 1,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);
    localparam int LL = $clog2(WIDTH);
    localparam int NG = (LL + PIPE_EVERY - 1) / PIPE_EVERY;

    // Prefix vectors: index 0 is position -1 (carry-in), index i is bit i-1.
    // Shifting in zeros is safe: once a span reaches index 0 the group
    // propagate is 0 anyway because position -1 never propagates.
    function automatic logic [WIDTH-1:0] ks_g(input logic [WIDTH-1:0] g,
                                              input logic [WIDTH-1:0] p,
                                              input int lo, input int hi);
        logic [WIDTH-1:0] gt, pt;
        gt = g;
        pt = p;
        for (int k = 0; k < LL; k++) begin
            if (k >= lo && k < hi) begin
                gt = gt | (pt & (gt << (1 << k)));
                pt = pt & (pt << (1 << k));
            end
        end
        return gt;
    endfunction

    function automatic logic [WIDTH-1:0] ks_p(input logic [WIDTH-1:0] p,
                                              input int lo, input int hi);
        logic [WIDTH-1:0] pt;
        pt = p;
        for (int k = 0; k < LL; k++) begin
            if (k >= lo && k < hi) pt = pt & (pt << (1 << k));
        end
        return pt;
    endfunction

    logic [NG:0]              vld_q, vld_d, load;
    logic [NG-1:0][WIDTH-1:0] gg_q, gg_d, pp_q, pp_d, p_q, p_d;
    logic [NG-1:0]            gmsb_q, gmsb_d, sub_q, sub_d;
    logic [NG-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [WIDTH-1:0]         sum_q, sum_d;
    logic                     cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
    logic [TAG_W-1:0]         otag_q, otag_d;

    logic [WIDTH-1:0] b_x, g_in, p_in, g_fin, sum_fin;
    logic             c0, c_msb, c_out;

    // A stage may load when it, or every stage after it, can move on.
    for (genvar s = 0; s <= NG; s++) begin : g_load
        assign load[s] = out_ready || !(&vld_q[NG:s]);
    end

    assign in_ready = load[0] && !rst;

    always_comb begin
        vld_d  = vld_q;
        gg_d   = gg_q;
        pp_d   = pp_q;
        p_d    = p_q;
        gmsb_d = gmsb_q;
        sub_d  = sub_q;
        tag_d  = tag_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        otag_d = otag_q;

        b_x  = in_b ^ {WIDTH{in_sub}};
        c0   = in_cin ^ in_sub;
        g_in = in_a & b_x;
        p_in = in_a ^ b_x;

        if (load[0]) begin
            vld_d[0] = in_valid;
            if (in_valid) begin
                gg_d[0]   = {g_in[WIDTH-2:0], c0};
                pp_d[0]   = {p_in[WIDTH-2:0], 1'b0};
                p_d[0]    = p_in;
                gmsb_d[0] = g_in[WIDTH-1];
                sub_d[0]  = in_sub;
                tag_d[0]  = in_tag;
            end
        end

        for (int s = 1; s < NG; s++) begin
            if (load[s]) begin
                vld_d[s] = vld_q[s-1];
                if (vld_q[s-1]) begin
                    gg_d[s]   = ks_g(gg_q[s-1], pp_q[s-1], (s-1)*PIPE_EVERY, s*PIPE_EVERY);
                    pp_d[s]   = ks_p(pp_q[s-1], (s-1)*PIPE_EVERY, s*PIPE_EVERY);
                    p_d[s]    = p_q[s-1];
                    gmsb_d[s] = gmsb_q[s-1];
                    sub_d[s]  = sub_q[s-1];
                    tag_d[s]  = tag_q[s-1];
                end
            end
        end

        // Last group of levels; g_fin[i] is the carry into bit i.
        g_fin   = ks_g(gg_q[NG-1], pp_q[NG-1], (NG-1)*PIPE_EVERY, NG*PIPE_EVERY);
        sum_fin = p_q[NG-1] ^ g_fin;
        c_msb   = g_fin[WIDTH-1];
        c_out   = gmsb_q[NG-1] | (p_q[NG-1][WIDTH-1] & c_msb);

        if (load[NG]) begin
            vld_d[NG] = vld_q[NG-1];
            if (vld_q[NG-1]) begin
                sum_d  = sum_fin;
                cout_d = c_out ^ sub_q[NG-1];
                ovf_d  = c_msb ^ c_out;
                zero_d = ~|sum_fin;
                otag_d = tag_q[NG-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            gg_q   <= '0;
            pp_q   <= '0;
            p_q    <= '0;
            gmsb_q <= '0;
            sub_q  <= '0;
            tag_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            otag_q <= '0;
        end else begin
            vld_q  <= vld_d;
            gg_q   <= gg_d;
            pp_q   <= pp_d;
            p_q    <= p_d;
            gmsb_q <= gmsb_d;
            sub_q  <= sub_d;
            tag_q  <= tag_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            otag_q <= otag_d;
        end
    end

    assign out_valid = vld_q[NG];
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;
    assign out_tag   = otag_q;

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Bench for ks_adder_pipe: directed 8-bit vectors, backpressure, reset flush,
// and random streams on two 32-bit configurations against a signed/unsigned model.
module tb_ks_adder_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // 8-bit, one level per stage (latency 4)
    logic       iv8, ir8, cin8, sub8, ov8, or8, co8, of8, z8;
    logic [7:0] a8, b8, s8;
    logic [3:0] t8, ot8;

    ks_adder_pipe #(.WIDTH(8), .PIPE_EVERY(1), .TAG_W(4)) u_d8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
        .in_cin(cin8), .in_sub(sub8), .in_tag(t8), .out_valid(ov8), .out_ready(or8),
        .out_sum(s8), .out_cout(co8), .out_ovf(of8), .out_zero(z8), .out_tag(ot8));

    // Two 32-bit configurations sharing one random stimulus stream
    logic        iv32, cin32, sub32, or32;
    logic [31:0] a32, b32;
    logic [3:0]  t32;
    logic        ira, ova, coa, ofa, za, irb, ovb, cob, ofb, zb;
    logic [31:0] sa, sb;
    logic [3:0]  ota, otb;

    ks_adder_pipe #(.WIDTH(32), .PIPE_EVERY(2), .TAG_W(4)) u_d32a (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ira), .in_a(a32), .in_b(b32),
        .in_cin(cin32), .in_sub(sub32), .in_tag(t32), .out_valid(ova), .out_ready(or32),
        .out_sum(sa), .out_cout(coa), .out_ovf(ofa), .out_zero(za), .out_tag(ota));

    ks_adder_pipe #(.WIDTH(32), .PIPE_EVERY(5), .TAG_W(4)) u_d32b (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(irb), .in_a(a32), .in_b(b32),
        .in_cin(cin32), .in_sub(sub32), .in_tag(t32), .out_valid(ovb), .out_ready(or32),
        .out_sum(sb), .out_cout(cob), .out_ovf(ofb), .out_zero(zb), .out_tag(otb));

    typedef struct packed {
        logic [3:0]  tag;
        logic        zero;
        logic        ovf;
        logic        cout;
        logic [31:0] sum;
    } res_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        logic       zero;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference: true signed result decides overflow, unsigned compare decides carry/borrow.
    function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub, input logic [3:0] tag);
        longint mod, half, ua, ub, sav, sbv, ci, res, us;
        res_t r;
        mod  = longint'(1) << w;
        half = mod >> 1;
        ua   = longint'(a) & (mod - 1);
        ub   = longint'(b) & (mod - 1);
        ci   = cin ? 1 : 0;
        sav  = (ua >= half) ? ua - mod : ua;
        sbv  = (ub >= half) ? ub - mod : ub;
        if (sub) begin
            res    = sav - sbv - ci;
            r.cout = (ua < ub + ci);
        end else begin
            res    = sav + sbv + ci;
            r.cout = (ua + ub + ci >= mod);
        end
        r.ovf  = (res < -half) || (res >= half);
        us     = res & (mod - 1);
        r.sum  = us[31:0];
        r.zero = (us == 0);
        r.tag  = tag;
        return r;
    endfunction

    function automatic res_t r8();
        res_t r;
        r.sum = {24'd0, s8}; r.cout = co8; r.ovf = of8; r.zero = z8; r.tag = ot8;
        return r;
    endfunction

    function automatic res_t ra();
        res_t r;
        r.sum = sa; r.cout = coa; r.ovf = ofa; r.zero = za; r.tag = ota;
        return r;
    endfunction

    function automatic res_t rb();
        res_t r;
        r.sum = sb; r.cout = cob; r.ovf = ofb; r.zero = zb; r.tag = otb;
        return r;
    endfunction

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vec[8];
        res_t exp_r, hold_r;
        res_t q8[$];
        res_t qa[$];
        res_t qb[$];
        int   lat, sent, n_got, stall, acc_a, acc_b;
        logic first_seen, saw_full, hold_ok, have_hold, done;

        //            a      b     cin   sub   sum   cout  ovf   zero
        vec[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vec[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        vec[2] = '{8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vec[3] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vec[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0};
        vec[5] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
        vec[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        vec[7] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};

        rst = 1'b1;
        iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; t8 = '0; or8 = 1'b1;
        iv32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; t32 = '0; or32 = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {ir8, ira, irb}, 3'b000);
        chk("rst_out8", {ov8, r8()}, 0);
        chk("rst_out32", {ova, ovb}, 2'b00);
        rst = 1'b0;

        // Directed vectors, one at a time, with latency measurement
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a8 = vec[i].a; b8 = vec[i].b; cin8 = vec[i].cin; sub8 = vec[i].sub;
            t8 = 4'(i); iv8 = 1'b1; or8 = 1'b1;
            #1;
            chk($sformatf("dir%0d_in_ready", i), ir8, 1'b1);
            @(negedge clk);
            iv8 = 1'b0;
            lat = 1;
            while (!ov8 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("dir%0d_latency", i), lat, 4);
            exp_r.sum = {24'd0, vec[i].sum}; exp_r.cout = vec[i].cout;
            exp_r.ovf = vec[i].ovf; exp_r.zero = vec[i].zero; exp_r.tag = 4'(i);
            chk($sformatf("dir%0d_result", i), r8(), exp_r);
        end

        // Backpressure: 8 back-to-back ops, output stalled 5 cycles at first result
        @(negedge clk);
        sent = 0; n_got = 0; stall = 0;
        first_seen = 1'b0; saw_full = 1'b0; hold_ok = 1'b1; have_hold = 1'b0;
        for (int cyc = 0; cyc < 200 && n_got < 8; cyc++) begin
            if (ov8) first_seen = 1'b1;
            if (first_seen && stall < 5) begin
                or8 = 1'b0;
                stall++;
            end else begin
                or8 = 1'b1;
            end
            if (sent < 8) begin
                iv8 = 1'b1; a8 = 8'(sent * 17); b8 = 8'(sent + 3);
                cin8 = sent[0]; sub8 = sent[1]; t8 = 4'(sent);
            end else begin
                iv8 = 1'b0;
            end
            #1;
            if (!ir8) saw_full = 1'b1;
            if (ov8 && !or8) begin
                if (have_hold && r8() !== hold_r) hold_ok = 1'b0;
                hold_r = r8();
                have_hold = 1'b1;
            end else begin
                have_hold = 1'b0;
            end
            if (iv8 && ir8) begin
                q8.push_back(model(8, {24'd0, a8}, {24'd0, b8}, cin8, sub8, t8));
                sent++;
            end
            if (ov8 && or8) begin
                if (q8.size() == 0) chk("bp_spurious", 1'b1, 1'b0);
                else begin
                    exp_r = q8.pop_front();
                    chk($sformatf("bp_result%0d", n_got), r8(), exp_r);
                end
                n_got++;
            end
            @(negedge clk);
        end
        iv8 = 1'b0; or8 = 1'b1;
        chk("bp_count", n_got, 8);
        chk("bp_in_ready_fell", saw_full, 1'b1);
        chk("bp_hold_stable", hold_ok, 1'b1);

        // Reset with 3 ops in flight, then one fresh op
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            iv8 = 1'b1; a8 = 8'(k + 1); b8 = 8'h10; cin8 = 1'b0; sub8 = 1'b0; t8 = 4'(k + 8);
            @(negedge clk);
        end
        iv8 = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstmid_in_ready", ir8, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_flush", ov8, 1'b0);
        iv8 = 1'b1; a8 = 8'h21; b8 = 8'h12; cin8 = 1'b0; sub8 = 1'b0; t8 = 4'h5;
        #1;
        chk("rstmid_accept", ir8, 1'b1);
        @(negedge clk);
        iv8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("rstmid_latency", lat, 4);
        exp_r.sum = 32'h33; exp_r.cout = 1'b0; exp_r.ovf = 1'b0; exp_r.zero = 1'b0; exp_r.tag = 4'h5;
        chk("rstmid_result", r8(), exp_r);
        @(negedge clk);

        // Random streams on both 32-bit configurations
        acc_a = 0; acc_b = 0;
        for (int cyc = 0; cyc < 70000; cyc++) begin
            @(negedge clk);
            done = (acc_a >= 10000) && (acc_b >= 10000);
            if (done && qa.size() == 0 && qb.size() == 0) break;
            iv32  = !done && ($urandom_range(0, 9) < 7);
            or32  = done || ($urandom_range(0, 9) < 7);
            a32   = $urandom;
            b32   = $urandom;
            cin32 = 1'($urandom_range(0, 1));
            sub32 = 1'($urandom_range(0, 1));
            t32   = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 7))
                0: b32 = sub32 ? a32 - 32'(cin32) : 32'd0 - a32 - 32'(cin32);
                1: a32 = 32'h8000_0000;
                2: b32 = 32'hFFFF_FFFF;
                3: a32 = 32'h7FFF_FFFF;
                default: ;
            endcase
            #1;
            if (iv32 && ira) begin
                qa.push_back(model(32, a32, b32, cin32, sub32, t32));
                acc_a++;
            end
            if (iv32 && irb) begin
                qb.push_back(model(32, a32, b32, cin32, sub32, t32));
                acc_b++;
            end
            if (ova && or32) begin
                if (qa.size() == 0) chk("rnd_a_spurious", 1'b1, 1'b0);
                else begin
                    exp_r = qa.pop_front();
                    chk("rnd_a_result", ra(), exp_r);
                end
            end
            if (ovb && or32) begin
                if (qb.size() == 0) chk("rnd_b_spurious", 1'b1, 1'b0);
                else begin
                    exp_r = qb.pop_front();
                    chk("rnd_b_result", rb(), exp_r);
                end
            end
        end
        iv32 = 1'b0; or32 = 1'b1;
        chk("rnd_a_ops", acc_a >= 10000, 1'b1);
        chk("rnd_b_ops", acc_b >= 10000, 1'b1);
        chk("rnd_a_drained", qa.size(), 0);
        chk("rnd_b_drained", qb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
